// File: rtl/crc_pkg.sv
// Shared types, constants and the byte-wise CRC-16-CCITT update for crc_mem_writer.
package crc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StDone
  } wr_state_e;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // One byte through the CRC register, MSB first, no reflection.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ CRC_POLY;
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_mem_writer_if.sv
// Stream-in / memory-write-out bundle for crc_mem_writer.
interface crc_mem_writer_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
) ();

  logic              wr_start;
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_last;
  logic              data_ready;
  logic [ADDR_W-1:0] mem_addr_out;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_we;
  logic [ADDR_W:0]   wr_count;
  logic [15:0]       crc_out;
  logic              wr_done;

  modport master (
    output wr_start, data_in, data_valid, data_last,
    input  data_ready, mem_addr_out, mem_data_out, mem_we, wr_count, crc_out, wr_done
  );

  modport slave (
    input  wr_start, data_in, data_valid, data_last,
    output data_ready, mem_addr_out, mem_data_out, mem_we, wr_count, crc_out, wr_done
  );

endinterface

// File: rtl/crc16_byte_calc.sv
// Combinational CRC-16-CCITT update by one byte.
module crc16_byte_calc
  import crc_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  assign crc_o = crc16_byte(crc_i, data_i);

endmodule

// File: rtl/crc_mem_writer.sv
// Burst writer: accepts a byte stream, writes it to memory from address 0 with a
// registered write port, counts bytes and optionally tracks a CRC-16-CCITT.
// Optional feature macro: CRC_WR_CALC_EN (undefined -> crc_out tied to zero).
module crc_mem_writer
  import crc_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
) (
  input logic              clk50m,
  input logic              rst,
  crc_mem_writer_if.slave  bus
);

  localparam logic [ADDR_W:0] Depth   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LastPtr = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] CntOne  = {{ADDR_W{1'b0}}, 1'b1};

  wr_state_e         state_q, state_d;
  logic [ADDR_W:0]   cnt_q;  // write pointer and byte count share one register
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              we_q;

  logic ready, accept, start, done;

  // State register.
  always_ff @(posedge clk50m) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state: leave WRITE on a last beat or on the final address.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.wr_start) state_d = StWrite;
      StWrite: if (accept && (bus.data_last || cnt_q == LastPtr)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Decoded per-state controls.
  always_comb begin
    ready  = (state_q == StWrite) && (cnt_q < Depth);
    accept = ready && bus.data_valid;
    start  = (state_q == StIdle) && bus.wr_start;
    done   = (state_q == StDone);
  end

  // Registered memory write port and byte counter.
  always_ff @(posedge clk50m) begin
    if (rst) begin
      cnt_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
    end else begin
      we_q <= accept;
      if (start) begin
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q  <= cnt_q + CntOne;
        addr_q <= cnt_q[ADDR_W-1:0];
        data_q <= bus.data_in;
      end
    end
  end

`ifdef CRC_WR_CALC_EN
  logic [15:0] crc_q, crc_next;

  crc16_byte_calc u_crc (
    .crc_i  (crc_q),
    .data_i (bus.data_in[7:0]),
    .crc_o  (crc_next)
  );

  // CRC register updates on the same edge that registers the write.
  always_ff @(posedge clk50m) begin
    if (rst)         crc_q <= '0;
    else if (start)  crc_q <= CRC_INIT;
    else if (accept) crc_q <= crc_next;
  end

  assign bus.crc_out = crc_q;
`else
  assign bus.crc_out = 16'h0000;
`endif

  assign bus.data_ready   = ready;
  assign bus.wr_done      = done;
  assign bus.mem_we       = we_q;
  assign bus.mem_addr_out = addr_q;
  assign bus.mem_data_out = data_q;
  assign bus.wr_count     = cnt_q;

endmodule

// File: tb/tb_crc_mem_writer.sv
// Scoreboard bench for crc_mem_writer: a behavioural model queues expected writes,
// a negedge monitor pops and compares them against the memory port.
module tb_crc_mem_writer;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic clk50m = 1'b0;
  logic rst    = 1'b1;

  crc_mem_writer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  crc_mem_writer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk50m (clk50m),
    .rst    (rst),
    .bus    (bus)
  );

  always #10 clk50m = ~clk50m;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic [15:0]   crc;
  } wr_t;

  wr_t         exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          phase = 0;  // 0 idle, 1 writing, 2 done
  int          cnt = 0;
  logic [15:0] crc_ref = 16'h0000;
  int          done_exp = 0;
  int          done_seen = 0;
  bit          model_on = 1'b0;

  // Polynomial long division form: fold the byte into the top, shift out 8 bits.
  function automatic logic [15:0] ref_crc_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  function automatic logic [15:0] crc_model_out();
`ifdef CRC_WR_CALC_EN
    return crc_ref;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behaviour of one rising edge given the inputs held across it.
  task automatic model_edge(input logic s, input logic v, input logic l, input logic [7:0] d,
                            input logic r);
    if (r) begin
      phase = 0; cnt = 0; crc_ref = 16'h0000;
    end else begin
      case (phase)
        0: if (s) begin phase = 1; cnt = 0; crc_ref = 16'hFFFF; end
        1: if (v && cnt < DEPTH) begin
          crc_ref = ref_crc_step(crc_ref, d);
          exp_q.push_back(wr_t'{addr: cnt[AW-1:0], data: d, crc: crc_model_out()});
          cnt++;
          if (l || cnt == DEPTH) begin phase = 2; done_exp++; end
        end
        default: phase = 0;
      endcase
    end
  endtask

  task automatic step(input logic s, input logic v, input logic l, input logic [7:0] d,
                      input logic r);
    bus.wr_start   = s;
    bus.data_valid = v;
    bus.data_last  = l;
    bus.data_in    = d;
    rst            = r;
    if (model_on) chk("data_ready", {31'b0, bus.data_ready}, {31'b0, (phase == 1 && cnt < DEPTH)});
    @(posedge clk50m);
    model_edge(s, v, l, d, r);
    model_on = 1'b1;
    #1;
  endtask

  task automatic end_check(input string tag, input int n, input logic [15:0] crc_spec);
    repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk({tag, " wr_count"}, {21'b0, bus.wr_count}, n);
    chk({tag, " crc_out"}, {16'b0, bus.crc_out}, {16'b0, crc_spec});
    chk({tag, " wr_done pulses"}, done_seen, done_exp);
    chk({tag, " pending writes"}, exp_q.size(), 0);
  endtask

  // Monitor: every cycle compare wr_done and any memory write against the model.
  always @(negedge clk50m) begin
    wr_t e;
    if (model_on) begin
      chk("wr_done", {31'b0, bus.wr_done}, {31'b0, (phase == 2)});
      if (bus.wr_done === 1'b1) done_seen++;
      if (bus.mem_we !== 1'b0) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL mem_we: got write at addr 0x%0h, expected no write", bus.mem_addr_out);
        end else begin
          e = exp_q.pop_front();
          chk("mem_addr_out", {22'b0, bus.mem_addr_out}, {22'b0, e.addr});
          chk("mem_data_out", {24'b0, bus.mem_data_out}, {24'b0, e.data});
          chk("crc_out", {16'b0, bus.crc_out}, {16'b0, e.crc});
        end
      end
    end
  end

  initial begin
    string msg;
    int    idx, len, sent;
    logic  v;
    msg = "123456789";
    bus.wr_start = 1'b0; bus.data_valid = 1'b0; bus.data_last = 1'b0; bus.data_in = '0;
    @(posedge clk50m); #1;

    // Two reset cycles; every output must read zero.
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("rst mem_we", {31'b0, bus.mem_we}, 0);
    chk("rst mem_addr_out", {22'b0, bus.mem_addr_out}, 0);
    chk("rst mem_data_out", {24'b0, bus.mem_data_out}, 0);
    chk("rst wr_count", {21'b0, bus.wr_count}, 0);
    chk("rst crc_out", {16'b0, bus.crc_out}, 0);
    chk("rst wr_done", {31'b0, bus.wr_done}, 0);
    chk("rst data_ready", {31'b0, bus.data_ready}, 0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // "123456789" with data_last on '9'.
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, (i == 8), msg[i], 1'b0);
`ifdef CRC_WR_CALC_EN
    end_check("ascii", 9, 16'h29B1);
`else
    end_check("ascii", 9, 16'h0000);
`endif
    chk("ascii done once", done_seen, 1);

    // Full-depth burst without data_last; extra valid beats must be refused.
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < DEPTH + 6; i++) step(1'b0, 1'b1, 1'b0, i[7:0], 1'b0);
    end_check("full", DEPTH, crc_model_out());
    chk("full done once", done_seen, 2);

    // Toggled valid with wr_start re-pulsed mid-burst.
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      idx = i / 2;
      v   = (i % 2 == 0);
      step((i == 3 || i == 4), v, v && (idx == 3), 8'(8'hA0 + idx), 1'b0);
    end
    end_check("toggle", 4, crc_model_out());

    // Reset after 5 accepted bytes with a beat in flight, then a 2-byte burst.
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h50 + i), 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h77, 1'b1);
    chk("midrst wr_count", {21'b0, bus.wr_count}, 0);
    chk("midrst crc_out", {16'b0, bus.crc_out}, 0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h11, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'h22, 1'b0);
    end_check("after rst", 2, crc_model_out());

    // Random bursts: gaps, stray wr_start, valid data while idle.
    for (int b = 0; b < 20; b++) begin
      repeat ($urandom_range(1, 3)) step(1'b0, 1'($urandom % 2), 1'b0, 8'($urandom), 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      len  = int'($urandom_range(1, 40));
      sent = 0;
      while (sent < len) begin
        v = ($urandom % 10) < 7;
        if (v) sent++;
        step(($urandom % 8) == 0, v, v && (sent == len), 8'($urandom), 1'b0);
      end
      end_check("random", len, crc_model_out());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/crc_mem_writer.md
CRC_MEM_WRITER -- requirements
Module: crc_mem_writer

Interface
REQ-001 Parameter ADDR_W, default 10, memory address width; memory depth is 2**ADDR_W.
REQ-002 Parameter DATA_W, default 8, byte width of the stream and memory word.
REQ-003 The block SHALL have one clock and a synchronous active-high reset: clk50m and rst.
REQ-004 clk50m  input  1  system clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 wr_start  input  1  pulse; starts a new write burst at address 0.
REQ-007 data_in  input  DATA_W  stream byte.
REQ-008 data_valid  input  1  data_in valid.
REQ-009 data_last  input  1  marks the final byte of a burst; qualified by data_valid.
REQ-010 data_ready  output  1  block accepts a byte this cycle.
REQ-011 mem_addr_out  output  ADDR_W  memory write address.
REQ-012 mem_data_out  output  DATA_W  memory write data.
REQ-013 mem_we  output  1  memory write strobe, one cycle per byte.
REQ-014 wr_count  output  ADDR_W+1  bytes written in current/last burst.
REQ-015 crc_out  output  16  CRC of bytes written in current/last burst.
REQ-016 wr_done  output  1  one-cycle pulse at burst end.

Function
REQ-017 States: IDLE, WRITE, DONE; encoding is implementation-defined.
REQ-018 IDLE: data_ready=0; wr_start=1 -> WRITE; wr_count clears to 0; CRC register loads 0xFFFF; write pointer clears to 0.
REQ-019 WRITE: data_ready=1 while pointer < 2**ADDR_W; a beat is accepted when data_valid && data_ready.
REQ-020 On an accepted beat, the next cycle SHALL show mem_we=1, mem_addr_out=pointer, mem_data_out=data_in (registered, latency 1); pointer and wr_count increment.
REQ-021 mem_we SHALL be 0 in every cycle not following an accepted beat; gaps in data_valid produce no writes.
REQ-022 Accepted beat with data_last=1, or accepted beat at pointer 2**ADDR_W-1 -> DONE; data_ready drops the next cycle; no address wrap-around.
REQ-023 DONE: wr_done=1 for exactly one cycle -> IDLE; wr_count and crc_out hold until the next wr_start.
REQ-024 wr_start in WRITE or DONE SHALL be ignored; data_valid in IDLE/DONE SHALL NOT be accepted.
REQ-025 CRC: CRC-16-CCITT, polynomial 0x1021, init 0xFFFF, MSB first, no reflection, no final XOR; updated once per accepted byte, result visible on crc_out in the cycle mem_we is asserted for that byte.

Reset
REQ-026 rst=1 SHALL force IDLE, pointer=0, wr_count=0, data_ready=0, mem_we=0, mem_addr_out=0, mem_data_out=0, wr_done=0, crc_out=0 on the next rising edge, including mid-burst; an in-flight beat is discarded.

Configuration
REQ-027 Macro CRC_WR_CALC_EN defined: CRC logic is present per REQ-025.
REQ-028 CRC_WR_CALC_EN undefined: no CRC logic; crc_out is tied to 16'h0000; all other behaviour is unchanged.

Structure
REQ-029 Package crc_pkg SHALL hold the state enum type, CRC_POLY=16'h1021, CRC_INIT=16'hFFFF and a crc16_byte update function.
REQ-030 Sub-module crc16_byte_calc (combinational byte-wise CRC update, instanced under CRC_WR_CALC_EN) is the only sub-module.

Verification
REQ-031 Assert rst for 2 cycles -> all outputs 0, data_ready=0.
REQ-032 wr_start, stream ASCII "123456789" with data_last on '9' -> writes to addr 0..8, wr_count=9, crc_out=0x29B1, one wr_done pulse.
REQ-033 wr_start, 1024 bytes 0x00..0xFF repeating, no data_last -> last write at addr 1023, wr_count=1024, data_ready=0 afterwards, wr_done once.
REQ-034 Stream 4 bytes with data_valid toggled 1,0,1,0,... and wr_start re-pulsed mid-burst -> exactly 4 mem_we pulses, addresses 0..3, burst not restarted.
REQ-035 rst after 5 accepted bytes, then new wr_start with 2 bytes -> writes at addr 0,1; wr_count=2.
REQ-036 Build without CRC_WR_CALC_EN, repeat REQ-032 -> same writes and wr_count, crc_out=0x0000.
